// File: rtl/uart_rx_byte.sv
// uart_rx_byte: serial-to-byte receiver feeding the command decoder.
// Reassembles 8N1 frames from the asynchronous rx line and presents each good
// byte on a held data_out bus with a one-cycle data_valid strobe. Framing and
// parity faults pulse an error flag and the faulty byte is dropped.
// Optional feature macro: UART_RX_PARITY_EN adds an even-parity bit between
// the last data bit and the stop bit (8E1 framing).
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int HALF = CLKS_PER_BIT / 2;

  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] PARITY    = 3'd3;
`endif
  localparam logic [2:0] STOP      = 3'd4;
  localparam logic [2:0] WAIT_HIGH = 3'd5;

`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] AFTER_DATA = PARITY;
`else
  localparam logic [2:0] AFTER_DATA = STOP;
`endif

  logic          rx_meta;
  logic          rx_s;
  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          bit_done;
  logic          parity_bad;

`ifdef UART_RX_PARITY_EN
  logic parity_bit;
  logic parity_err_q;

  assign parity_bad = (^shreg) ^ parity_bit;
  assign parity_err = parity_err_q;
`else
  assign parity_bad = 1'b0;
  assign parity_err = 1'b0;
`endif

  assign bit_done = (cnt == CNT_LAST);
  assign busy     = (state != IDLE);

  // Two-flop synchroniser; flops come out of reset at the idle line level so
  // a reset never manufactures a falling edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Frame state machine: bit timing, shift register, output strobes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= 3'd0;
      shreg      <= 8'h00;
      data_out   <= 8'h00;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bit   <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          cnt <= '0;
          if (!rx_s) begin
            state <= START;
          end
        end

        START: begin
          if (cnt == CNT_HALF) begin
            cnt <= '0;
            if (!rx_s) begin
              state   <= DATA;
              bit_idx <= 3'd0;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        DATA: begin
          if (bit_done) begin
            cnt            <= '0;
            shreg[bit_idx] <= rx_s;
            if (bit_idx == 3'd7) begin
              bit_idx <= 3'd0;
              state   <= AFTER_DATA;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (bit_done) begin
            cnt        <= '0;
            parity_bit <= rx_s;
            state      <= STOP;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
`endif

        STOP: begin
          if (bit_done) begin
            cnt <= '0;
            if (rx_s) begin
              state <= IDLE;
              if (parity_bad) begin
`ifdef UART_RX_PARITY_EN
                parity_err_q <= 1'b1;
`endif
              end else begin
                data_out   <= shreg;
                data_valid <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_HIGH;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        WAIT_HIGH: begin
          cnt <= '0;
          if (rx_s) begin
            state <= IDLE;
          end
        end

        default: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_byte.sv
// tb_uart_rx_byte: self-checking bench for uart_rx_byte at CLKS_PER_BIT = 16.
// Good frames come from a vector table; glitch, framing error, reset mid-frame
// and parity cases are hand-written sequences. Expected bytes go into a
// scoreboard queue as frames are driven and are popped on each data_valid.
module tb_uart_rx_byte;

  localparam int CPB = 16;

  logic       clk;
  logic       reset;
  logic       rx;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  int checks = 0;
  int passes = 0;
  int valid_cnt = 0;
  int frame_cnt = 0;
  int parity_cnt = 0;
  logic [7:0] exp_q[$];
  logic last_parity_sent;

  typedef struct {
    logic [7:0] data;
    logic       stop_bit;
    logic       exp_valid;
    logic       exp_frame;
    logic [7:0] exp_data_out;
  } vec_t;

  vec_t vecs[6];

  uart_rx_byte #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .busy       (busy)
  );

  // Free-running 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case any sequence stalls.
  initial begin
    #1_000_000;
    $display("[TB] FAIL global_timeout: simulation did not finish, passed %0d of %0d", passes, checks);
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    end
  endtask

  // Scoreboard: every data_valid must match the oldest pending expected byte.
  always @(negedge clk) begin
    if (data_valid) begin
      valid_cnt++;
      checkOutput("sb_expect_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        checkOutput("sb_data_out", 32'(data_out), 32'(exp_q.pop_front()));
      end
    end
    if (frame_err) frame_cnt++;
    if (parity_err) parity_cnt++;
  end

  // Drives one bit for a full bit period; caller is aligned to a negedge.
  task automatic send_bit(input logic b);
    rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  // Sends one frame LSB first; flip_par inverts the even-parity bit.
  task automatic applyStimulus(input logic [7:0] data, input logic stop_bit, input logic flip_par);
    last_parity_sent = (^data) ^ flip_par;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(data[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(last_parity_sent);
`endif
    send_bit(stop_bit);
  endtask

  task automatic idle_cycles(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Waits up to max_cycles for busy to drop; reports whether it did.
  task automatic wait_not_busy(input string name, input int max_cycles);
    logic dropped;
    dropped = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (!busy) begin
        dropped = 1'b1;
        break;
      end
    end
    checkOutput(name, 32'(dropped), 32'd1);
  endtask

  initial begin
    int v0, f0, p0, busy_low;

    vecs[0] = '{8'hFF, 1'b1, 1'b1, 1'b0, 8'hFF};
    vecs[1] = '{8'h15, 1'b1, 1'b1, 1'b0, 8'h15};
    vecs[2] = '{8'h00, 1'b1, 1'b1, 1'b0, 8'h00};
    vecs[3] = '{8'h80, 1'b1, 1'b1, 1'b0, 8'h80};
    vecs[4] = '{8'h01, 1'b1, 1'b1, 1'b0, 8'h01};
    vecs[5] = '{8'hA5, 1'b1, 1'b1, 1'b0, 8'hA5};

    reset = 1'b0;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_data_out",   32'(data_out),   32'h00);
    checkOutput("reset_data_valid", 32'(data_valid), 32'd0);
    checkOutput("reset_frame_err",  32'(frame_err),  32'd0);
    checkOutput("reset_parity_err", 32'(parity_err), 32'd0);
    checkOutput("reset_busy",       32'(busy),       32'd0);
    reset = 1'b1;
    idle_cycles(4);

    // Back-to-back good frames from the table, no idle gap between them.
    for (int i = 0; i < 6; i++) begin
      v0 = valid_cnt;
      f0 = frame_cnt;
      if (vecs[i].exp_valid) exp_q.push_back(vecs[i].exp_data_out);
      applyStimulus(vecs[i].data, vecs[i].stop_bit, 1'b0);
      checkOutput($sformatf("vec%0d_valid_pulses", i), 32'(valid_cnt - v0), 32'(vecs[i].exp_valid));
      checkOutput($sformatf("vec%0d_frame_pulses", i), 32'(frame_cnt - f0), 32'(vecs[i].exp_frame));
      checkOutput($sformatf("vec%0d_data_out", i), 32'(data_out), 32'(vecs[i].exp_data_out));
    end
    idle_cycles(2 * CPB);

    // Start glitch: 5 low cycles must be rejected silently.
    v0 = valid_cnt;
    f0 = frame_cnt;
    rx = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("glitch_busy_seen", 32'(busy), 32'd1);
    rx = 1'b1;
    wait_not_busy("glitch_busy_falls", 10);
    idle_cycles(2 * CPB);
    checkOutput("glitch_no_valid", 32'(valid_cnt - v0), 32'd0);
    checkOutput("glitch_no_frame", 32'(frame_cnt - f0), 32'd0);

    // Framing error: good 0xA5, then 0x3C with stop low and line held low.
    exp_q.push_back(8'hA5);
    applyStimulus(8'hA5, 1'b1, 1'b0);
    v0 = valid_cnt;
    f0 = frame_cnt;
    p0 = parity_cnt;
    applyStimulus(8'h3C, 1'b0, 1'b0);
    busy_low = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) busy_low++;
    end
    checkOutput("ferr_busy_held", 32'(busy_low), 32'd0);
    checkOutput("ferr_pulses", 32'(frame_cnt - f0), 32'd1);
    checkOutput("ferr_no_parity", 32'(parity_cnt - p0), 32'd0);
    checkOutput("ferr_no_valid", 32'(valid_cnt - v0), 32'd0);
    checkOutput("ferr_data_held", 32'(data_out), 32'hA5);
    rx = 1'b1;
    wait_not_busy("ferr_busy_release", 10);
    idle_cycles(CPB);
    exp_q.push_back(8'h02);
    applyStimulus(8'h02, 1'b1, 1'b0);
    checkOutput("ferr_next_byte", 32'(data_out), 32'h02);
    idle_cycles(CPB);

    // Reset for one cycle in the middle of data bit 4 of 0x81.
    v0 = valid_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1 & (i == 0));
    rx = 1'b0;
    repeat (CPB / 2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("midrst_data_out",   32'(data_out),   32'h00);
    checkOutput("midrst_data_valid", 32'(data_valid), 32'd0);
    checkOutput("midrst_frame_err",  32'(frame_err),  32'd0);
    checkOutput("midrst_parity_err", 32'(parity_err), 32'd0);
    checkOutput("midrst_busy",       32'(busy),       32'd0);
    reset = 1'b1;
    idle_cycles(3 * CPB);
    checkOutput("midrst_no_valid", 32'(valid_cnt - v0), 32'd0);
    exp_q.push_back(8'h01);
    applyStimulus(8'h01, 1'b1, 1'b0);
    checkOutput("midrst_next_byte", 32'(data_out), 32'h01);
    idle_cycles(CPB);

`ifdef UART_RX_PARITY_EN
    // Even parity: 0x07 needs a parity bit of 1.
    v0 = valid_cnt;
    p0 = parity_cnt;
    exp_q.push_back(8'h07);
    applyStimulus(8'h07, 1'b1, 1'b0);
    checkOutput("par_good_valid", 32'(valid_cnt - v0), 32'd1);
    checkOutput("par_good_data", 32'(data_out), 32'h07);
    checkOutput("par_good_no_err", 32'(parity_cnt - p0), 32'd0);
    v0 = valid_cnt;
    applyStimulus(8'h07, 1'b1, 1'b1);
    checkOutput("par_bad_pulse", 32'(parity_cnt - p0), 32'd1);
    checkOutput("par_bad_no_valid", 32'(valid_cnt - v0), 32'd0);
    checkOutput("par_bad_data_held", 32'(data_out), 32'h07);
    idle_cycles(CPB);
`else
    checkOutput("no_parity_pulses", 32'(parity_cnt), 32'd0);
`endif

    idle_cycles(2 * CPB);
    checkOutput("sb_queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] last parity bit driven: %0b", last_parity_sent);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
